// File: rtl/load_store_unit_if.sv
// Pipeline-side bundle of the load/store unit: MEM-stage instruction fields,
// data-memory request/response and the status pulses returned to the pipeline.
interface load_store_unit_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);
  logic                     valid;
  logic                     load;
  logic                     store;
  logic [2:0]               fun3;
  logic [AddrWidth-1:0]     alu_out_address;
  logic [DataWidth-1:0]     operand_b;
  logic [DataWidth-1:0]     wrap_load_in;
  logic                     data_valid;
  logic                     request;
  logic                     we_re;
  logic [AddrWidth-1:0]     mem_addr;
  logic [DataWidth/8-1:0]   mask;
  logic [DataWidth-1:0]     store_data_out;
  logic [DataWidth-1:0]     load_data_out;
  logic                     load_done;
  logic                     stall;
  logic                     misaligned;
  logic                     bus_error;

  // The unit itself sits on the slave side.
  modport slave (
    input  valid, load, store, fun3, alu_out_address, operand_b,
           wrap_load_in, data_valid,
    output request, we_re, mem_addr, mask, store_data_out, load_data_out,
           load_done, stall, misaligned, bus_error
  );

  modport master (
    output valid, load, store, fun3, alu_out_address, operand_b,
           wrap_load_in, data_valid,
    input  request, we_re, mem_addr, mask, store_data_out, load_data_out,
           load_done, stall, misaligned, bus_error
  );
endinterface

// File: rtl/load_store_unit.sv
// Sequential rv32i MEM-stage load/store unit: registered request/response toward
// data memory, lane masks, store replication, load extension, misalign and timeout.
module load_store_unit #(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = 15
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  localparam int NB = DataWidth / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   request_q, request_d;
  logic                   we_re_q, we_re_d;
  logic [AddrWidth-1:0]   mem_addr_q, mem_addr_d;
  logic [NB-1:0]          mask_q, mask_d;
  logic [DataWidth-1:0]   store_data_q, store_data_d;
  logic [DataWidth-1:0]   load_data_q, load_data_d;
  logic                   load_done_q, load_done_d;
  logic                   misaligned_q, misaligned_d;
  logic                   bus_error_q, bus_error_d;
  size_t                  size_q, size_d;
  logic                   uns_q, uns_d;
  logic [OB-1:0]          off_q, off_d;

  size_t                  size;
  logic                   uns;
  logic [OB-1:0]          off;
  logic                   aligned;
  logic                   start;
  logic                   accept;
  logic [NB-1:0]          mask_new;
  logic [DataWidth-1:0]   store_rep;
  logic [DataWidth-1:0]   shifted;
  logic [DataWidth-1:0]   load_ext;

  assign off   = bus.alu_out_address[OB-1:0];
  assign start = bus.valid & (bus.load | bus.store);
  // The bus_error cycle still holds the stalled instruction; it must not be retried.
  assign accept = ~rst & ~bus_error_q & start & (state_q == ST_IDLE);

  always_comb begin
    size = SZ_W;
    uns  = 1'b0;
    case (bus.fun3)
      3'b000:  size = SZ_B;
      3'b100:  begin size = SZ_B; uns = 1'b1; end
      3'b001:  size = SZ_H;
      3'b101:  begin size = SZ_H; uns = 1'b1; end
      3'b011:  size = (DataWidth == 64) ? SZ_D : SZ_W;
      3'b110:  uns = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    aligned  = 1'b1;
    mask_new = '1;
    case (size)
      SZ_B: mask_new = NB'(1) << off;
      SZ_H: begin
        aligned  = ~off[0];
        mask_new = NB'(3) << off;
      end
      SZ_W: begin
        aligned  = (off[1:0] == 2'b00);
        mask_new = NB'(15) << off;
      end
      default: aligned = (off == '0);
    endcase
  end

  // Each lane picks the byte of operand_b that lands there when the access
  // size is replicated across the whole bus.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign store_rep[gi*8 +: 8] =
          (size == SZ_B) ? bus.operand_b[7:0] :
          (size == SZ_H) ? bus.operand_b[(gi % 2)*8 +: 8] :
          (size == SZ_W) ? bus.operand_b[(gi % 4)*8 +: 8] :
                           bus.operand_b[gi*8 +: 8];
    end
  endgenerate

  assign shifted = bus.wrap_load_in >> {off_q, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (size_q)
      SZ_B: load_ext = uns_q ? DataWidth'(shifted[7:0])
                             : DataWidth'($signed(shifted[7:0]));
      SZ_H: load_ext = uns_q ? DataWidth'(shifted[15:0])
                             : DataWidth'($signed(shifted[15:0]));
      SZ_W: load_ext = uns_q ? DataWidth'(shifted[31:0])
                             : DataWidth'($signed(shifted[31:0]));
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    request_d    = request_q;
    we_re_d      = we_re_q;
    mem_addr_d   = mem_addr_q;
    mask_d       = mask_q;
    store_data_d = store_data_q;
    load_data_d  = load_data_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    load_done_d  = 1'b0;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (aligned) begin
            state_d    = ST_WAIT;
            cnt_d      = '0;
            request_d  = 1'b1;
            we_re_d    = bus.store;
            mem_addr_d = {bus.alu_out_address[AddrWidth-1:OB], {OB{1'b0}}};
            mask_d     = mask_new;
            size_d     = size;
            uns_d      = uns;
            off_d      = off;
            if (bus.store) begin
              store_data_d = store_rep;
            end
          end else begin
            misaligned_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // A response on the expiry cycle still wins over the timeout.
        if (bus.data_valid) begin
          state_d   = ST_DONE;
          request_d = 1'b0;
          if (!we_re_q) begin
            load_data_d = load_ext;
            load_done_d = 1'b1;
          end
        end else if (cnt_q == CW'(TimeoutCycles - 1)) begin
          state_d     = ST_IDLE;
          request_d   = 1'b0;
          bus_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      request_q    <= 1'b0;
      we_re_q      <= 1'b0;
      mem_addr_q   <= '0;
      mask_q       <= '0;
      store_data_q <= '0;
      load_data_q  <= '0;
      load_done_q  <= 1'b0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      off_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      request_q    <= request_d;
      we_re_q      <= we_re_d;
      mem_addr_q   <= mem_addr_d;
      mask_q       <= mask_d;
      store_data_q <= store_data_d;
      load_data_q  <= load_data_d;
      load_done_q  <= load_done_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
    end
  end

  assign bus.stall          = (accept & aligned) | (state_q == ST_WAIT);
  assign bus.request        = request_q;
  assign bus.we_re          = we_re_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mask           = mask_q;
  assign bus.store_data_out = store_data_q;
  assign bus.load_data_out  = load_data_q;
  assign bus.load_done      = load_done_q;
  assign bus.misaligned     = misaligned_q;
  assign bus.bus_error      = bus_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_load_store_unit;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int T  = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if #(.DataWidth(DW), .AddrWidth(AW)) bus();

  load_store_unit #(.DataWidth(DW), .AddrWidth(AW), .TimeoutCycles(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  // Model: age counts cycles since the accept cycle (1 = first request cycle).
  int          age;
  int          resp_k;
  logic        t_load;
  logic [1:0]  t_off;
  logic [2:0]  t_f3;
  logic        r_request, r_we, r_ldone, r_mis, r_berr;
  logic [31:0] r_addr, r_sdata, r_ldata;
  logic [3:0]  r_mask;
  logic        e_request, e_we, e_ldone, e_mis, e_berr, e_stall;
  logic [31:0] e_addr, e_sdata, e_ldata;
  logic [3:0]  e_mask;

  logic        i_valid, i_load, i_store;
  logic [2:0]  i_f3;
  logic [31:0] i_addr, i_opb;
  int          plan_k;
  logic        rd_fix;
  logic [31:0] rd_val;
  logic        m_stall;
  int          n_stall, n_ldone, n_berr;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic f_aligned(logic [2:0] f3, logic [1:0] off);
    if (f3[1:0] == 2'b00) return 1'b1;
    if (f3[1:0] == 2'b01) return off[0] == 1'b0;
    return off == 2'b00;
  endfunction

  function automatic logic [3:0] f_mask(logic [2:0] f3, logic [1:0] off);
    if (f3[1:0] == 2'b00) return 4'b0001 << off;
    if (f3[1:0] == 2'b01) return 4'b0011 << off;
    return 4'hF;
  endfunction

  function automatic logic [31:0] f_rep(logic [31:0] opb, logic [2:0] f3);
    if (f3[1:0] == 2'b00) return (opb & 32'hFF) * 32'h01010101;
    if (f3[1:0] == 2'b01) return (opb & 32'hFFFF) * 32'h00010001;
    return opb;
  endfunction

  function automatic logic [31:0] f_load(logic [31:0] rd, logic [1:0] off, logic [2:0] f3);
    logic [31:0] v;
    v = rd >> (off * 8);
    if (f3[1:0] == 2'b00) begin
      v = v & 32'hFF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (f3[1:0] == 2'b01) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic model_reset();
    age = -1; resp_k = 0; t_load = 0; t_off = 0; t_f3 = 0;
    r_request = 0; r_we = 0; r_ldone = 0; r_mis = 0; r_berr = 0;
    r_addr = 0; r_sdata = 0; r_ldata = 0; r_mask = 0;
    e_request = 0; e_we = 0; e_ldone = 0; e_mis = 0; e_berr = 0; e_stall = 0;
    e_addr = 0; e_sdata = 0; e_ldata = 0; e_mask = 0;
    m_stall = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("request",    32'(bus.request),    32'(e_request));
      chk("we_re",      32'(bus.we_re),      32'(e_we));
      chk("mem_addr",   bus.mem_addr,        e_addr);
      chk("mask",       32'(bus.mask),       32'(e_mask));
      chk("store_data", bus.store_data_out,  e_sdata);
      chk("load_data",  bus.load_data_out,   e_ldata);
      chk("load_done",  32'(bus.load_done),  32'(e_ldone));
      chk("misaligned", 32'(bus.misaligned), 32'(e_mis));
      chk("bus_error",  32'(bus.bus_error),  32'(e_berr));
      chk("stall",      32'(bus.stall),      32'(e_stall));
    end
  end

  // One clock cycle: apply inputs, publish expectations, advance the model.
  task automatic drive_cycle();
    logic waiting, dv, blk, acc, al;
    logic [1:0] off;
    bus.valid           = i_valid;
    bus.load            = i_load;
    bus.store           = i_store;
    bus.fun3            = i_f3;
    bus.alu_out_address = i_addr;
    bus.operand_b       = i_opb;
    bus.wrap_load_in    = rd_fix ? rd_val : $urandom;
    waiting = (age >= 1) && (age <= T) && (resp_k == 0 || age <= resp_k);
    dv      = waiting && (age == resp_k);
    blk     = (age >= 1) && !waiting;
    bus.data_valid = waiting ? dv : ($urandom_range(0, 5) == 0);
    off = i_addr[1:0];
    al  = f_aligned(i_f3, off);
    acc = !waiting && !blk && i_valid && (i_load || i_store);
    e_request = r_request; e_we = r_we; e_addr = r_addr; e_mask = r_mask;
    e_sdata = r_sdata; e_ldata = r_ldata; e_ldone = r_ldone; e_mis = r_mis;
    e_berr = r_berr;
    e_stall = (acc && al) || waiting;
    @(negedge clk);
    #1;
    n_stall += int'(bus.stall);
    n_ldone += int'(bus.load_done);
    n_berr  += int'(bus.bus_error);
    m_stall = e_stall;
    r_ldone = waiting && dv && t_load;
    if (waiting && dv && t_load) r_ldata = f_load(bus.wrap_load_in, t_off, t_f3);
    r_berr    = waiting && !dv && (age == T);
    r_mis     = acc && !al;
    r_request = (acc && al) || (waiting && !dv && age < T);
    if (acc && al) begin
      r_we   = i_store;
      r_addr = {i_addr[31:2], 2'b00};
      r_mask = f_mask(i_f3, off);
      if (i_store) r_sdata = f_rep(i_opb, i_f3);
      t_load = !i_store; t_f3 = i_f3; t_off = off;
      resp_k = plan_k;
      age    = 1;
    end else if (age >= 1) begin
      age = blk ? -1 : age + 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it while the model says the pipe is stalled.
  task automatic do_instr(logic l, logic s, logic [2:0] f3, logic [31:0] a,
                          logic [31:0] opb, logic [31:0] rd, int k);
    i_valid = 1; i_load = l; i_store = s; i_f3 = f3; i_addr = a; i_opb = opb;
    plan_k = k; rd_fix = 1; rd_val = rd;
    n_stall = 0; n_ldone = 0; n_berr = 0;
    for (int n = 0; n < 40; n++) begin
      drive_cycle();
      if (!m_stall) break;
    end
    if (m_stall) begin
      total++; bad++;
      $display("FAIL instr_bound actual=stalled required=done t=%0t", $time);
    end
    i_valid = 0; i_load = 0; i_store = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, sel;
    rst = 1;
    i_valid = 0; i_load = 0; i_store = 0; i_f3 = 0; i_addr = 0; i_opb = 0;
    plan_k = 1; rd_fix = 0; rd_val = 0;
    bus.valid = 0; bus.load = 0; bus.store = 0; bus.fun3 = 0;
    bus.alu_out_address = 0; bus.operand_b = 0; bus.wrap_load_in = 0;
    bus.data_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_request",   32'(bus.request), 0);
    chk("rst_we_re",     32'(bus.we_re), 0);
    chk("rst_mask",      32'(bus.mask), 0);
    chk("rst_addr",      bus.mem_addr, 0);
    chk("rst_ldata",     bus.load_data_out, 0);
    chk("rst_sdata",     bus.store_data_out, 0);
    chk("rst_stall",     32'(bus.stall), 0);
    chk("rst_flags",     {29'b0, bus.load_done, bus.misaligned, bus.bus_error}, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk_en = 1;

    do_instr(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3);
    chk("lw_stall_cycles", n_stall, 4);
    chk("lw_done_count",   n_ldone, 1);
    chk("lw_data",         bus.load_data_out, 32'hDEADBEEF);
    chk("lw_mask",         32'(bus.mask), 32'hF);
    chk("lw_addr",         bus.mem_addr, 32'h100);

    do_instr(1, 0, 3'b000, 32'h103, 0, 32'h80112233, 1);
    chk("lb_stall_cycles", n_stall, 2);
    chk("lb_data",         bus.load_data_out, 32'hFFFFFF80);
    do_instr(1, 0, 3'b100, 32'h103, 0, 32'h80112233, 2);
    chk("lbu_data",        bus.load_data_out, 32'h00000080);

    do_instr(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 0, 2);
    chk("sh_mask",         32'(bus.mask), 32'hC);
    chk("sh_sdata",        bus.store_data_out, 32'hABCDABCD);
    chk("sh_we_re",        32'(bus.we_re), 1);
    chk("sh_done_count",   n_ldone, 0);
    chk("sh_ldata_held",   bus.load_data_out, 32'h00000080);

    do_instr(1, 0, 3'b010, 32'h101, 0, 0, 1);
    chk("mis_pulse",       32'(bus.misaligned), 1);
    chk("mis_request",     32'(bus.request), 0);
    chk("mis_stall_cycles", n_stall, 0);
    drive_cycle();

    do_instr(1, 0, 3'b010, 32'h104, 0, 0, 0);
    chk("to_stall_cycles", n_stall, T + 1);
    chk("to_berr_count",   n_berr, 1);
    chk("to_request",      32'(bus.request), 0);

    // Boundary: response on the very cycle the wait counter expires.
    do_instr(1, 0, 3'b010, 32'h108, 0, 32'h5A5A0001, T);
    chk("edge_berr_count", n_berr, 0);
    chk("edge_data",       bus.load_data_out, 32'h5A5A0001);

    i_valid = 1; i_load = 1; i_store = 0; i_f3 = 3'b010; i_addr = 32'h200;
    plan_k = 0; rd_fix = 0;
    repeat (3) drive_cycle();
    chk_en = 0;
    i_valid = 0; i_load = 0;
    bus.valid = 0;
    rst = 1;
    #1;
    chk("arst_request", 32'(bus.request), 0);
    chk("arst_stall",   32'(bus.stall), 0);
    chk("arst_mask",    32'(bus.mask), 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk_en = 1;
    do_instr(1, 0, 3'b010, 32'h300, 0, 32'h12345678, 2);
    chk("post_rst_data",  bus.load_data_out, 32'h12345678);
    chk("post_rst_done",  n_ldone, 1);
    chk("post_rst_stall", n_stall, 3);

    rd_fix = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!m_stall) begin
        i_valid = ($urandom_range(0, 9) < 7);
        sel     = $urandom_range(0, 3);
        i_load  = (sel == 0) || (sel == 2);
        i_store = (sel == 1) || (sel == 2);
        i_f3    = 3'($urandom);
        i_addr  = $urandom;
        i_opb   = $urandom;
      end
      r = $urandom_range(0, 9);
      if (r < 7)       plan_k = $urandom_range(1, 4);
      else if (r == 7) plan_k = T;
      else if (r == 8) plan_k = $urandom_range(5, T - 1);
      else             plan_k = 0;
      drive_cycle();
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
